// File: rtl/spi_slave_lbus_param.sv
// SPI mode-0 slave bridging serial frames onto a simple local bus.
// A frame is an 8-bit command, an address, then any number of data
// words. Command 0x01 writes and 0x02 reads; any other command makes
// the slave ignore the rest of the frame. reset_spi marks frame
// boundaries and is held high between frames.
module spi_slave_lbus_param #(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 1,
    parameter int AUTO_INC   = 1
) (
    input  logic                      sclk,
    input  logic                      reset_spi,
    input  logic                      mosi,
    output logic                      miso,
    input  logic [8*DATA_BYTES-1:0]   rdata,
    output logic                      rd_en,
    output logic                      rd_stb,
    output logic                      wr_en,
    output logic [8*DATA_BYTES-1:0]   wdata,
    output logic [8*ADDR_BYTES-1:0]   address
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    // The shift register has to hold the widest field: address or data word.
    localparam int SW = (AW > DW) ? AW : DW;
    localparam logic [DW-1:0] MSB_MASK = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    state_t          state;
    logic [5:0]      cnt;
    logic [SW-2:0]   sr;
    logic            is_read;
    logic [SW-1:0]   shifted;

    // The incoming bit joins the held bits so a field can be captured on
    // the very edge that completes it.
    assign shifted = {sr, mosi};

    // Rising-edge frame decoder: bit counting, address and data capture, strobes.
    always_ff @(posedge sclk or posedge reset_spi) begin
        if (reset_spi) begin
            state   <= CMD;
            cnt     <= '0;
            sr      <= '0;
            is_read <= 1'b0;
            address <= '0;
            wdata   <= '0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            rd_stb  <= 1'b0;
        end else begin
            sr     <= shifted[SW-2:0];
            wr_en  <= 1'b0;
            rd_stb <= 1'b0;
            case (state)
                CMD: begin
                    if (cnt == 6'd7) begin
                        cnt <= '0;
                        if (shifted[7:0] == 8'h01) begin
                            state   <= ADDR;
                            is_read <= 1'b0;
                        end else if (shifted[7:0] == 8'h02) begin
                            state   <= ADDR;
                            is_read <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ADDR: begin
                    if (cnt == 6'(AW - 1)) begin
                        address <= shifted[AW-1:0];
                        cnt     <= '0;
                        if (is_read) begin
                            state  <= RDATA;
                            rd_en  <= 1'b1;
                            rd_stb <= 1'b1;
                        end else begin
                            state <= WDATA;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                WDATA: begin
                    // The write lands at the old address, so step it one edge later.
                    if (wr_en && (AUTO_INC != 0)) begin
                        address <= address + AW'(1);
                    end
                    if (cnt == 6'(DW - 1)) begin
                        cnt   <= '0;
                        wdata <= shifted[DW-1:0];
                        wr_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                RDATA: begin
                    // Moving to the next address at word end gives the bus half
                    // a period to present the next word before its MSB goes out.
                    if (cnt == 6'(DW - 1)) begin
                        cnt    <= '0;
                        rd_stb <= 1'b1;
                        if (AUTO_INC != 0) begin
                            address <= address + AW'(1);
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                IGNORE: begin
                    cnt <= cnt;
                end
                default: begin
                    state <= CMD;
                end
            endcase
        end
    end

    // Falling-edge serializer: shifts the current read word out MSB first.
    always_ff @(negedge sclk or posedge reset_spi) begin
        if (reset_spi) begin
            miso <= 1'b0;
        end else if (state == RDATA) begin
            miso <= |(rdata & (MSB_MASK >> cnt));
        end else begin
            miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_lbus_param.sv
// Self-checking bench for spi_slave_lbus_param: a default instance and
// a 24-bit-address / 16-bit-data / no-increment instance share the SPI
// wires. Expected bus events are queued as frames are driven and are
// popped by monitors when the DUT strobes.
module tb_spi_slave_lbus_param;

    logic        sclk;
    logic        reset_spi;
    logic        mosi;

    logic        miso0, rd_en0, rd_stb0, wr_en0;
    logic [7:0]  rdata0, wdata0;
    logic [15:0] address0;

    logic        miso1, rd_en1, rd_stb1, wr_en1;
    logic [15:0] rdata1, wdata1;
    logic [23:0] address1;

    int tests = 0;
    int fails = 0;
    int bitIdx = 0;
    int rdEnFirst = -1;
    int rdEnCount = 0;
    bit dut0Active = 0;
    bit dut1Active = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          bitN;
    } wr_exp_t;

    typedef struct {
        logic [15:0] addr;
        int          nWords;
        logic [7:0]  data [3];
        int          extraBits;
        logic [15:0] finalAddr;
    } wr_vec_t;

    wr_exp_t wrQ0[$];
    wr_exp_t wrQ1[$];
    int      stbQ0[$];

    spi_slave_lbus_param dut0 (
        .sclk      (sclk),
        .reset_spi (reset_spi),
        .mosi      (mosi),
        .miso      (miso0),
        .rdata     (rdata0),
        .rd_en     (rd_en0),
        .rd_stb    (rd_stb0),
        .wr_en     (wr_en0),
        .wdata     (wdata0),
        .address   (address0)
    );

    spi_slave_lbus_param #(
        .ADDR_BYTES (3),
        .DATA_BYTES (2),
        .AUTO_INC   (0)
    ) dut1 (
        .sclk      (sclk),
        .reset_spi (reset_spi),
        .mosi      (mosi),
        .miso      (miso1),
        .rdata     (rdata1),
        .rd_en     (rd_en1),
        .rd_stb    (rd_stb1),
        .wr_en     (wr_en1),
        .wdata     (wdata1),
        .address   (address1)
    );

    // Memory contents as seen by the read port, a fixed function of address.
    function automatic logic [7:0] memModel(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign rdata0 = memModel(address0);
    assign rdata1 = {address1[7:0], address1[15:8]};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (bit %0d)", name, act, exp, bitIdx);
        end
    endtask

    // One SPI bit: mosi set while sclk is low, miso sampled just before the rising edge.
    task automatic applyStimulus(input logic b, output logic m);
        mosi = b;
        #4;
        m = miso0;
        sclk = 1'b1;
        #5;
        sclk = 1'b0;
        bitIdx++;
        #1;
    endtask

    task automatic sendBits(input logic [31:0] v, input int n);
        logic m;
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(v[i], m);
        end
    endtask

    task automatic startFrame();
        reset_spi = 1'b1;
        #3;
        reset_spi = 1'b0;
        bitIdx    = 0;
        rdEnFirst = -1;
        rdEnCount = 0;
        #2;
    endtask

    task automatic readFrame(input logic [15:0] addr, input int nWords);
        logic [7:0]  got;
        logic [15:0] a;
        logic        m;
        startFrame();
        dut0Active = 1;
        for (int w = 0; w <= nWords; w++) begin
            stbQ0.push_back(23 + 8 * w);
        end
        sendBits(32'h02, 8);
        sendBits({16'h0, addr}, 16);
        for (int w = 0; w < nWords; w++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(1'($urandom_range(0, 1)), m);
                got[7-j] = m;
            end
            a = addr + 16'(w);
            checkOutput("readByte", {24'h0, got}, {24'h0, memModel(a)});
        end
        checkOutput("rdEnFirst", rdEnFirst, 23);
        checkOutput("rdEnHold", {31'h0, rd_en0}, 1);
        checkOutput("rdStbCount", stbQ0.size(), 0);
        stbQ0.delete();
        dut0Active = 0;
    endtask

    // Default instance monitor: every strobe must match the head of its queue.
    always @(posedge sclk) begin
        wr_exp_t e;
        int      s;
        #1;
        if (dut0Active && wr_en0) begin
            if (wrQ0.size() == 0) begin
                checkOutput("wrUnexpected0", {31'h0, wr_en0}, 0);
            end else begin
                e = wrQ0.pop_front();
                checkOutput("wrAddr0", {16'h0, address0}, e.addr);
                checkOutput("wrData0", {24'h0, wdata0}, e.data);
                checkOutput("wrBit0", bitIdx, e.bitN);
            end
        end
        if (dut0Active && rd_stb0) begin
            if (stbQ0.size() == 0) begin
                checkOutput("stbUnexpected0", {31'h0, rd_stb0}, 0);
            end else begin
                s = stbQ0.pop_front();
                checkOutput("stbBit0", bitIdx, s);
            end
        end
        if (dut0Active && rd_en0) begin
            rdEnCount++;
            if (rdEnFirst < 0) rdEnFirst = bitIdx;
        end
    end

    // Wide instance monitor for its write frame.
    always @(posedge sclk) begin
        wr_exp_t e;
        #1;
        if (dut1Active && wr_en1) begin
            if (wrQ1.size() == 0) begin
                checkOutput("wrUnexpected1", {31'h0, wr_en1}, 0);
            end else begin
                e = wrQ1.pop_front();
                checkOutput("wrAddr1", {8'h0, address1}, e.addr);
                checkOutput("wrData1", {16'h0, wdata1}, e.data);
                checkOutput("wrBit1", bitIdx, e.bitN);
            end
        end
    end

    initial begin
        wr_vec_t     vecs [4];
        wr_exp_t     e;
        logic [15:0] a;
        logic        m;
        int          misoOnes;

        sclk      = 1'b0;
        mosi      = 1'b0;
        reset_spi = 1'b1;
        #5;

        // Reset state
        checkOutput("rstMiso", {31'h0, miso0}, 0);
        checkOutput("rstRdEn", {31'h0, rd_en0}, 0);
        checkOutput("rstWrEn", {31'h0, wr_en0}, 0);
        checkOutput("rstAddr", {16'h0, address0}, 0);
        checkOutput("rstWdata", {24'h0, wdata0}, 0);

        vecs[0] = '{16'h1234, 1, '{8'hA5, 8'h00, 8'h00}, 1, 16'h1235};
        vecs[1] = '{16'hFFFF, 2, '{8'h3C, 8'hC3, 8'h00}, 0, 16'h0000};
        vecs[2] = '{16'h0010, 3, '{8'h00, 8'hFF, 8'h81}, 5, 16'h0013};
        vecs[3] = '{16'h8000, 0, '{8'h00, 8'h00, 8'h00}, 7, 16'h8000};

        // Table-driven write frames, trailing partial word discarded
        for (int v = 0; v < 4; v++) begin
            startFrame();
            dut0Active = 1;
            for (int w = 0; w < vecs[v].nWords; w++) begin
                a      = vecs[v].addr + 16'(w);
                e.addr = {16'h0, a};
                e.data = {24'h0, vecs[v].data[w]};
                e.bitN = 24 + 8 * w + 7;
                wrQ0.push_back(e);
            end
            sendBits(32'h01, 8);
            sendBits({16'h0, vecs[v].addr}, 16);
            for (int w = 0; w < vecs[v].nWords; w++) begin
                sendBits({24'h0, vecs[v].data[w]}, 8);
            end
            sendBits(32'h5, vecs[v].extraBits);
            checkOutput("wrQueueLeft", wrQ0.size(), 0);
            checkOutput("finalAddr", {16'h0, address0}, {16'h0, vecs[v].finalAddr});
            checkOutput("noRdEnWrite", rdEnCount, 0);
            wrQ0.delete();
            dut0Active = 0;
        end

        // Read burst across a page boundary
        readFrame(16'h00FF, 3);
        checkOutput("rdFinalAddr", {16'h0, address0}, 32'h0102);

        // Unknown command: frame ignored
        startFrame();
        dut0Active = 1;
        misoOnes   = 0;
        sendBits(32'h03, 8);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), m);
            if (m !== 1'b0) misoOnes++;
        end
        checkOutput("ignMiso", misoOnes, 0);
        checkOutput("ignRdEn", rdEnCount, 0);
        checkOutput("ignAddr", {16'h0, address0}, 0);
        dut0Active = 0;

        // Reset in the middle of the second data word
        startFrame();
        dut0Active = 1;
        e.addr = 32'h0042;
        e.data = 32'h77;
        e.bitN = 31;
        wrQ0.push_back(e);
        sendBits(32'h01, 8);
        sendBits(32'h0042, 16);
        sendBits(32'h77, 8);
        sendBits(32'hA, 4);
        checkOutput("preAbortAddr", {16'h0, address0}, 32'h0043);
        reset_spi = 1'b1;
        #2;
        sclk = 1'b1;
        #5;
        sclk = 1'b0;
        #2;
        checkOutput("abortWrEn", {31'h0, wr_en0}, 0);
        checkOutput("abortWdata", {24'h0, wdata0}, 0);
        checkOutput("abortAddr", {16'h0, address0}, 0);
        checkOutput("abortRdStb", {31'h0, rd_stb0}, 0);
        checkOutput("abortMiso", {31'h0, miso0}, 0);
        checkOutput("abortQueue", wrQ0.size(), 0);
        wrQ0.delete();
        dut0Active = 0;
        readFrame(16'h0042, 1);

        // Wide instance: fixed address for the whole burst
        startFrame();
        dut1Active = 1;
        e.addr = 32'h012345;
        e.data = 32'hBEEF;
        e.bitN = 47;
        wrQ1.push_back(e);
        e.data = 32'hCAFE;
        e.bitN = 63;
        wrQ1.push_back(e);
        sendBits(32'h01, 8);
        sendBits(32'h012345, 24);
        sendBits(32'hBEEF, 16);
        sendBits(32'hCAFE, 16);
        mosi = 1'b0;
        sendBits(32'h0, 2);
        checkOutput("wideQueueLeft", wrQ1.size(), 0);
        checkOutput("wideAddr", {8'h0, address1}, 32'h012345);
        dut1Active = 0;

        reset_spi = 1'b1;
        #10;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
